keystream_block_buffer: RTL and testbench
=========================================

// Module: keystream_block_buffer
// PURPOSE
//  Multi-bank buffer for serialised ChaCha20 keystream bytes. Collects DATA_SIZE-bit words from the
//  serialiser into NUM_BANKS independent blocks of BLOCK_WORDS words each (ping-pong for NUM_BANKS=2).
//  Presents each completed block in parallel to the XOR/Poly1305 stage over a valid/ready handshake.
//  Successor to the single-shot concatenator: adds backpressure, flush with zero-pad and ordered multi-bank release.
// PARAMETERS
//  DATA_SIZE    8   width of one input word (bits)
//  BLOCK_WORDS  64  words per block (one serialised 512-bit state matrix at DATA_SIZE=8)
//  NUM_BANKS    2   number of block banks, >=2, power of two
// PORTS
//  clk        in   1                     rising-edge clock
//  rst_n      in   1                     asynchronous active-low reset
//  in_valid   in   1                     in_data holds a valid word
//  in_data    in   DATA_SIZE             keystream word from serialiser
//  in_ready   out  1                     buffer can accept a word this cycle
//  flush      in   1                     close current partial block, zero-padding the remainder
//  out_valid  out  1                     out_block holds a complete block
//  out_ready  in   1                     consumer accepts out_block this cycle
//  out_block  out  DATA_SIZE x BLOCK_WORDS  block, element 0 = first word written
//  out_fill   out  $clog2(BLOCK_WORDS)+1 number of real (non-pad) words in out_block
//  blk_count  out  $clog2(NUM_BANKS)+1   number of banks currently FULL
// BEHAVIOUR
//  - Reset (async, rst_n=0): all banks EMPTY, wr_bank=rd_bank=0, wr_addr=0, in_ready=1, out_valid=0,
//    out_block all-zero, out_fill=0, blk_count=0. Bank storage cleared. Reset mid-fill discards all data.
//  - Per-bank state: EMPTY -> FILLING (first word accepted) -> FULL (last word or flush) -> EMPTY (released).
//  - Input accept: in_valid && in_ready. Word stored at bank[wr_bank][wr_addr]; wr_addr++.
//  - in_ready = 1 iff bank[wr_bank] is EMPTY or FILLING (combinational from registered state).
//  - Block close: accept with wr_addr==BLOCK_WORDS-1 -> bank FULL, fill=BLOCK_WORDS, wr_addr=0,
//    wr_bank=(wr_bank+1) mod NUM_BANKS. Same-cycle flush is ignored (block already complete).
//  - flush with wr_addr>0 (and no accept closing the block): words wr_addr..BLOCK_WORDS-1 written zero,
//    fill=wr_addr (+1 if a word is accepted the same cycle; that word is stored before padding), bank FULL,
//    advance wr_bank. flush with wr_addr==0 and no accept: no effect.
//  - Latency: bank closes on edge N; out_valid may assert from cycle N+1 (registered state only).
//  - out_valid = 1 iff bank[rd_bank] FULL; out_block/out_fill driven from bank[rd_bank], else all-zero/0.
//  - Release: out_valid && out_ready -> bank[rd_bank] EMPTY, rd_bank=(rd_bank+1) mod NUM_BANKS.
//    Banks always release in fill order; index wrap at NUM_BANKS-1 -> 0.
//  - Simultaneous release of bank k and accept into bank k (all banks FULL): not possible; in_ready=0 that
//    cycle, the freed bank accepts from the next cycle. Release and accept into different banks in the same
//    cycle are both performed.
//  - blk_count: +1 on close, -1 on release, unchanged when both occur same cycle; never exceeds NUM_BANKS.
//  - out_valid held with stable out_block/out_fill until accepted (no retraction).
//  - in_valid while in_ready=0: word not stored, not counted; serialiser must hold it.
// CONFIGURATION
//  KSB_ZEROIZE_EN defined: on release, the freed bank's storage is cleared to zero on the same edge
//   it returns to EMPTY (keystream hygiene); padding and out_block contents otherwise identical.
//  KSB_ZEROIZE_EN undefined: released bank keeps stale contents until overwritten; no clear logic
//   synthesised. Externally visible port behaviour is identical in both builds.
// TESTING
//  1) 128 words 0x00..0x7F back-to-back, out_ready=1 -> two blocks, out_block[0]=0x00 then 0x40, out_fill=64.
//  2) out_ready=0, 192 words offered -> in_ready drops after word 128, blk_count=2; out_ready=1 one cycle
//     -> bank 0 released, in_ready=1 next cycle, word 128 lands in bank 0 word 0.
//  3) 10 words 0xA0..0xA9 then flush -> out_fill=10, out_block[9]=0xA9, out_block[10..63]=0x00.
//  4) flush with word 63 accepted same cycle -> out_fill=64, no extra empty block; flush at wr_addr=0 -> nothing.
//  5) rst_n low mid-block (word 30) and while out_valid=1 -> out_valid=0, blk_count=0, in_ready=1 immediately.
//  6) KSB_ZEROIZE_EN build: after release, hierarchical peek of freed bank reads all-zero; undefined build
//     keeps old bytes; both builds produce identical port traces for scenarios 1-5.

Source files
------------

// File: rtl/keystream_block_buffer.sv
// Multi-bank keystream block buffer: collects serial words into NUM_BANKS blocks released in fill order.
// Optional KSB_ZEROIZE_EN: clears a bank's storage on the edge it is released.
module keystream_block_buffer #(
    parameter int unsigned DATA_SIZE   = 8,
    parameter int unsigned BLOCK_WORDS = 64,
    parameter int unsigned NUM_BANKS   = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    input  logic [DATA_SIZE-1:0]                   in_data,
    output logic                                   in_ready,
    input  logic                                   flush,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [BLOCK_WORDS-1:0][DATA_SIZE-1:0]  out_block,
    output logic [$clog2(BLOCK_WORDS):0]           out_fill,
    output logic [$clog2(NUM_BANKS):0]             blk_count
);

    localparam int unsigned AW = $clog2(BLOCK_WORDS);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned BW = $clog2(NUM_BANKS);
    localparam int unsigned CW = BW + 1;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_state_t;

    bank_state_t                           state_q [NUM_BANKS];
    bank_state_t                           state_d [NUM_BANKS];
    logic [BLOCK_WORDS-1:0][DATA_SIZE-1:0] mem     [NUM_BANKS];
    logic [FW-1:0]                         fill_q  [NUM_BANKS];
    logic [BW-1:0]                         wr_bank;
    logic [BW-1:0]                         rd_bank;
    logic [AW-1:0]                         wr_addr;

    logic accept;
    logic last_word;
    logic flush_close;
    logic close;
    logic release_blk;

    assign in_ready    = (state_q[wr_bank] != FULL);
    assign out_valid   = (state_q[rd_bank] == FULL);
    assign accept      = in_valid && in_ready;
    assign last_word   = accept && (wr_addr == AW'(BLOCK_WORDS - 1));
    // A flush closes the block only if it holds at least one real word after this edge.
    assign flush_close = flush && !last_word && (wr_addr != '0 || accept);
    assign close       = last_word || flush_close;
    assign release_blk = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (release_blk && BW'(b) == rd_bank) begin
                state_d[b] = EMPTY;
            end
            if (BW'(b) == wr_bank) begin
                if (close) begin
                    state_d[b] = FULL;
                end else if (accept) begin
                    state_d[b] = FILLING;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= EMPTY;
                fill_q[b]  <= '0;
            end
            wr_bank   <= '0;
            rd_bank   <= '0;
            wr_addr   <= '0;
            blk_count <= '0;
        end else begin
            state_q <= state_d;
            if (close) begin
                fill_q[wr_bank] <= last_word ? FW'(BLOCK_WORDS) : FW'(wr_addr) + FW'(accept);
                wr_addr         <= '0;
                wr_bank         <= wr_bank + BW'(1);
            end else if (accept) begin
                wr_addr <= wr_addr + AW'(1);
            end
            if (release_blk) begin
                rd_bank <= rd_bank + BW'(1);
            end
            if (close && !release_blk) begin
                blk_count <= blk_count + CW'(1);
            end else if (release_blk && !close) begin
                blk_count <= blk_count - CW'(1);
            end
        end
    end

    // Write bank and released bank never coincide: a FULL write bank blocks both accept and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                mem[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
`ifdef KSB_ZEROIZE_EN
                if (release_blk && BW'(b) == rd_bank) begin
                    mem[b] <= '0;
                end
`endif
                if (BW'(b) == wr_bank) begin
                    for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
                        if (accept && AW'(i) == wr_addr) begin
                            mem[b][i] <= in_data;
                        end else if (flush_close && AW'(i) >= wr_addr) begin
                            mem[b][i] <= '0;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        out_block = '0;
        out_fill  = '0;
        if (out_valid) begin
            out_block = mem[rd_bank];
            out_fill  = fill_q[rd_bank];
        end
    end

endmodule

// File: tb/tb_keystream_block_buffer.sv
// Scoreboard bench for keystream_block_buffer: word-queue reference model feeds expected blocks,
// a negedge monitor checks handshake state and pops blocks on every release.
module tb_keystream_block_buffer;

    localparam int unsigned DS = 8;
    localparam int unsigned BWORDS = 64;
    localparam int unsigned NB = 2;

    typedef logic [BWORDS-1:0][DS-1:0] blk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [DS-1:0] in_data = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    blk_t        out_block;
    logic [$clog2(BWORDS):0] out_fill;
    logic [$clog2(NB):0]     blk_count;

    keystream_block_buffer #(.DATA_SIZE(DS), .BLOCK_WORDS(BWORDS), .NUM_BANKS(NB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .out_fill(out_fill), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DS-1:0] partial[$];
    blk_t          exp_blk_q[$];
    int unsigned   exp_fill_q[$];
    int unsigned   n_full = 0;
    bit            exp_ready = 1'b1;
    bit            exp_ov = 1'b0;
    int unsigned   exp_cnt = 0;
    bit            last_acc = 1'b0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        partial.delete();
        exp_blk_q.delete();
        exp_fill_q.delete();
        n_full    = 0;
        exp_ready = 1'b1;
        exp_ov    = 1'b0;
        exp_cnt   = 0;
    endtask

    // One cycle of stimulus; the model advances by what the coming edge must do.
    task automatic step(input bit v, input logic [DS-1:0] d, input bit fl, input bit ordy);
        bit acc, rel, cl;
        blk_t blk;
        @(posedge clk); #2;
        in_valid = v; in_data = d; flush = fl; out_ready = ordy;
        exp_ready = (n_full < NB);
        exp_ov    = (n_full > 0);
        exp_cnt   = n_full;
        acc = v && exp_ready;
        rel = exp_ov && ordy;
        cl  = 1'b0;
        if (acc) partial.push_back(d);
        if (partial.size() == BWORDS) cl = 1'b1;
        else if (fl && partial.size() > 0) cl = 1'b1;
        if (cl) begin
            blk = '0;
            foreach (partial[i]) blk[i] = partial[i];
            exp_blk_q.push_back(blk);
            exp_fill_q.push_back(partial.size());
            partial.delete();
        end
        n_full   = n_full + int'(cl) - int'(rel);
        last_acc = acc;
    endtask

    task automatic send_words(input int unsigned first, input int unsigned n, input bit ordy);
        int unsigned k = 0;
        int unsigned guard = 0;
        while (k < n && guard < 1000) begin
            step(1'b1, DS'(first + k), 1'b0, ordy);
            if (last_acc) k++;
            guard++;
        end
        chk("send_timeout", guard < 1000, 1);
    endtask

    task automatic idle(input int unsigned n, input bit ordy);
        for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b0, ordy);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        model_clear();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_blk_count", blk_count, 0);
        chk("rst_out_fill", out_fill, 0);
        chk("rst_out_block_zero", out_block == '0, 1);
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on every accepted block.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, exp_ov);
            chk("blk_count", blk_count, exp_cnt);
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_blk_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_block: got fill %0d expected no block", out_fill);
                end else begin
                    blk_t eb;
                    int unsigned ef;
                    eb = exp_blk_q.pop_front();
                    ef = exp_fill_q.pop_front();
                    if (out_block !== eb) begin
                        n_fail++;
                        $display("FAIL block_data: got %h expected %h", out_block, eb);
                    end
                    chk("block_fill", out_fill, ef);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // 128 ascending words with a willing consumer
        send_words(0, 128, 1'b1);
        idle(4, 1'b1);
`ifdef KSB_ZEROIZE_EN
        chk("zeroize_bank1", dut.mem[1] == '0, 1);
`else
        chk("stale_bank1", dut.mem[1][5], 8'h45);
`endif

        // Backpressure: both banks fill, one release frees bank 0 for word 128
        send_words(0, 128, 1'b0);
        step(1'b1, 8'd128, 1'b0, 1'b0);
        step(1'b1, 8'd128, 1'b0, 1'b0);
        step(1'b1, 8'd128, 1'b0, 1'b1);
        send_words(128, 64, 1'b0);
        idle(2, 1'b0);
        idle(6, 1'b1);

        // Partial block closed by flush, zero-padded over stale bytes
        send_words(8'hA0, 10, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Flush coinciding with the last word, then a flush on an empty block
        send_words(8'h10, 63, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Reset mid-fill and while a block is presented
        send_words(8'h30, 30, 1'b0);
        do_reset();
        send_words(8'h50, 64, 1'b0);
        idle(2, 1'b0);
        do_reset();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, DS'($urandom), $urandom_range(0, 40) == 0,
                 $urandom_range(0, 2) != 0);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        idle(8, 1'b1);
        chk("scoreboard_empty", exp_blk_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
